keypad_scanner: RTL

Matrix-keypad front end for the microwave controller. Scans a 4-row × 3-column membrane keypad, synchronizes and debounces the row returns, and delivers each accepted digit press as a single-cycle one-hot pulse on the 10-bit `keypad` word that the microwave core consumes. `*` and `#` are reported on separate pulse outputs. It sits between the board pins and the microwave `keypad` input.

---
 rtl/microwave_pkg.sv | 30 +++
 rtl/keypad_scanner_row_sync.sv | 24 ++
 rtl/keypad_scanner.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave keypad front end: scanner states,
// keypad geometry and the (row, col) -> key code map.
package microwave_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 3;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_EMIT,
    ST_RELEASE
  } state_t;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;

  // Flattened map, entry (r*COLS + c) holds the key code; entry 0 is the low nibble.
  localparam logic [ROWS*COLS*4-1:0] KEY_MAP = {
    KEY_HASH, 4'd0, KEY_STAR,   // r3
    4'd9,     4'd8, 4'd7,       // r2
    4'd6,     4'd5, 4'd4,       // r1
    4'd3,     4'd2, 4'd1        // r0
  };

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    return KEY_MAP[(int'(r) * COLS + int'(c)) * 4 +: 4];
  endfunction

endpackage

// File: rtl/keypad_scanner_row_sync.sv
// Two-flop synchronizer for the asynchronous row returns; clears to all-ones
// so reset looks like "no key pressed".
module row_sync
  import microwave_pkg::*;
(
  input  logic            clk,
  input  logic            clearn,
  input  logic [ROWS-1:0] d,
  output logic [ROWS-1:0] q
);

  logic [ROWS-1:0] meta;

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: column scan, press/release debounce, and a
// registered single-cycle pulse per accepted key.
module keypad_scanner
  import microwave_pkg::*;
#(
  parameter int SCAN_DIV       = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic            clk,
  input  logic            clearn,
  input  logic [ROWS-1:0] row_n,
  output logic [COLS-1:0] col_n,
  output logic [9:0]      keypad,
  output logic            key_star,
  output logic            key_hash
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DWELL_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_SCANS - 1);

  logic [ROWS-1:0]  rows_s, rows_low;
  state_t           state, state_d;
  logic [1:0]       col, col_d, col_next;
  logic [DIV_W-1:0] dwell, dwell_d;
  logic [CNT_W-1:0] match, match_d, rel, rel_d;
  logic [1:0]       row_lat, row_lat_d, row_enc;
  logic             tick, single, idle, emit;
  logic [3:0]       code;
  logic [9:0]       keypad_d;
  logic             star_d, hash_d;

  row_sync u_sync (
    .clk    (clk),
    .clearn (clearn),
    .d      (row_n),
    .q      (rows_s)
  );

  always_comb begin
    rows_low = ~rows_s;
    idle     = (rows_low == '0);
    single   = !idle && ((rows_low & (rows_low - 4'd1)) == '0);
    row_enc  = 2'd0;
    for (int i = 0; i < ROWS; i++)
      if (rows_low[i]) row_enc = 2'(i);
    tick     = (dwell == DWELL_LAST);
    col_next = (col == 2'(COLS - 1)) ? 2'd0 : col + 2'd1;
  end

  always_comb begin
    state_d   = state;
    col_d     = col;
    match_d   = match;
    rel_d     = rel;
    row_lat_d = row_lat;
    emit      = 1'b0;
    dwell_d   = tick ? '0 : dwell + 1'b1;
    case (state)
      ST_SCAN: if (tick) begin
        if (single) begin
          row_lat_d = row_enc;
          match_d   = CNT_W'(1);
          if (DEBOUNCE_SCANS <= 1) begin
            state_d = ST_EMIT;
            emit    = 1'b1;
          end else begin
            state_d = ST_DEBOUNCE;
          end
        end else begin
          col_d = col_next;
        end
      end
      ST_DEBOUNCE: if (tick) begin
        if (single && row_enc == row_lat) begin
          if (match == CNT_LAST) begin
            state_d = ST_EMIT;
            emit    = 1'b1;
            match_d = '0;
          end else begin
            match_d = match + 1'b1;
          end
        end else begin
          state_d = ST_SCAN;
          col_d   = col_next;
          match_d = '0;
        end
      end
      ST_EMIT: begin
        // Restart the dwell so release sampling gets full-length dwells.
        state_d = ST_RELEASE;
        rel_d   = '0;
        dwell_d = '0;
      end
      ST_RELEASE: if (tick) begin
        if (idle) begin
          if (rel == CNT_LAST) begin
            state_d = ST_SCAN;
            col_d   = col_next;
            rel_d   = '0;
          end else begin
            rel_d = rel + 1'b1;
          end
        end else begin
          rel_d = '0;
        end
      end
      default: state_d = ST_SCAN;
    endcase

    code     = key_code(row_lat_d, col);
    keypad_d = (emit && code <= 4'd9) ? (10'd1 << code) : '0;
    star_d   = emit && (code == KEY_STAR);
    hash_d   = emit && (code == KEY_HASH);
  end

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      state    <= ST_SCAN;
      col      <= 2'd0;
      dwell    <= '0;
      match    <= '0;
      rel      <= '0;
      row_lat  <= 2'd0;
      col_n    <= 3'b110;
      keypad   <= '0;
      key_star <= 1'b0;
      key_hash <= 1'b0;
    end else begin
      state    <= state_d;
      col      <= col_d;
      dwell    <= dwell_d;
      match    <= match_d;
      rel      <= rel_d;
      row_lat  <= row_lat_d;
      col_n    <= ~(3'b001 << col_d);
      keypad   <= keypad_d;
      key_star <= star_d;
      key_hash <= hash_d;
    end
  end

endmodule
